axis_icap_writer: RTL and testbench

- Sink for the bitstream stream produced by the reconfiguration controller.
- Accepts wide AXI-Stream beats of partial bitstream data fetched by DMA and serialises them into 32-bit words for the ICAPE3 configuration port.
- Applies per-byte bit reversal and throttles on ICAP AVAIL.
- Reports per-frame word count, frame completion and tkeep errors.

---
 rtl/axis_icap_writer_if.sv | 14 +
 rtl/axis_icap_writer.sv | 162 ++++++++++++++++
 tb/tb_axis_icap_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_icap_writer_if.sv
// AXI-Stream beat bus carrying partial-bitstream data into the ICAP writer.
interface axis_icap_writer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_icap_writer.sv
// Serialises wide AXI-Stream bitstream beats into 32-bit ICAPE3 write words,
// throttled by icap_avail, with per-frame word counting and tkeep checking.
module axis_icap_writer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int BIT_SWAP   = 1,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_icap_writer_if.slave    s_axis,
    output logic                 icap_csib,
    output logic                 icap_rdwrb,
    output logic [31:0]          icap_i,
    input  logic                 icap_avail,
    output logic                 busy,
    output logic                 frame_done,
    output logic [LEN_WIDTH-1:0] word_count,
    output logic                 err_keep,
    input  logic                 err_clr
);
    localparam int LANES = DATA_WIDTH / 32;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic             tready_r;
    logic             new_frame;
    logic             last_beat;
    logic             fin_p1;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] nwords;
    logic [31:0]      lanes_p0 [LANES];

    logic             accept;
    logic             present;
    logic             issue;
    logic             issue_last;
    logic             issue_tlast;
    logic             in_keep_bad;
    logic [CNT_W-1:0] in_words;
    logic [CNT_W-1:0] idx_next;
    logic [31:0]      cur_word;

    function automatic logic [31:0] bit_order(input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (BIT_SWAP != 0)
            for (int b = 0; b < 4; b++)
                for (int i = 0; i < 8; i++)
                    r[b*8 + i] = w[b*8 + 7 - i];
        return r;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] c);
        return (&c) ? c : c + LEN_WIDTH'(1);
    endfunction

    // Only the full lanes below the first non-full nibble are emitted; anything
    // other than a clean all-ones prefix followed by zeros is a format error.
    always_comb begin
        logic gap;
        gap         = 1'b0;
        in_words    = '0;
        in_keep_bad = 1'b0;
        for (int l = 0; l < KEEP_WIDTH / 4; l++) begin
            if (!gap && s_axis.tkeep[l*4 +: 4] == 4'hF) begin
                in_words = in_words + CNT_W'(1);
            end else begin
                gap = 1'b1;
                if (s_axis.tkeep[l*4 +: 4] != 4'h0) in_keep_bad = 1'b1;
            end
        end
    end

    assign s_axis.tready = tready_r;
    assign icap_rdwrb    = 1'b0;
    assign accept        = tready_r && s_axis.tvalid;
    assign idx_next      = idx + CNT_W'(1);
    // Lane 0 of a freshly accepted beat goes straight from the bus to ICAP
    assign cur_word      = (state == IDLE) ? s_axis.tdata[31:0] : lanes_p0[idx[IDX_W-1:0]];
    assign present       = (state == SHIFT) || (accept && in_words != '0);
    assign issue         = present && icap_avail;
    assign issue_last    = (state == IDLE) ? (in_words == CNT_W'(1)) : (idx_next == nwords);
    assign issue_tlast   = (state == IDLE) ? s_axis.tlast : last_beat;

    always_ff @(posedge clk) begin
        if (accept)
            for (int l = 0; l < LANES; l++)
                lanes_p0[l] <= s_axis.tdata[l*32 +: 32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tready_r   <= 1'b0;
            icap_csib  <= 1'b1;
            icap_i     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            word_count <= '0;
            err_keep   <= 1'b0;
            idx        <= '0;
            nwords     <= '0;
            last_beat  <= 1'b0;
            new_frame  <= 1'b1;
            fin_p1     <= 1'b0;
        end else begin
            icap_csib  <= ~issue;
            frame_done <= fin_p1;
            fin_p1     <= 1'b0;
            if (present) icap_i <= bit_order(cur_word);

            if (accept && in_keep_bad) err_keep <= 1'b1;
            else if (err_clr)          err_keep <= 1'b0;

            if (issue) begin
                word_count <= new_frame ? LEN_WIDTH'(1) : sat_inc(word_count);
                new_frame  <= 1'b0;
                if (issue_last) begin
                    fin_p1    <= issue_tlast;
                    new_frame <= issue_tlast;
                end
            end

            case (state)
                IDLE: begin
                    tready_r <= 1'b1;
                    if (accept) begin
                        last_beat <= s_axis.tlast;
                        nwords    <= in_words;
                        if (in_words == '0) begin
                            if (s_axis.tlast) begin
                                frame_done <= 1'b1;
                                new_frame  <= 1'b1;
                            end
                        end else if (!(icap_avail && issue_last)) begin
                            state    <= SHIFT;
                            tready_r <= 1'b0;
                            busy     <= 1'b1;
                            idx      <= icap_avail ? CNT_W'(1) : '0;
                        end
                    end
                end
                SHIFT: begin
                    if (icap_avail) begin
                        idx <= idx_next;
                        // Reopen the input as the last lane goes out so the next beat follows gap-free
                        if (idx_next == nwords) begin
                            state    <= IDLE;
                            tready_r <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_icap_writer.sv
// Directed and randomized checks of axis_icap_writer against a word-list model.
module tb_axis_icap_writer;
    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int LANES = DW / 32;
    localparam int DW2   = 64;

    typedef struct {
        logic [31:0] w;
        int          c;
    } obs_t;

    logic        clk, rst;
    logic        icap_csib, icap_rdwrb, icap_avail, busy, frame_done, err_keep, err_clr;
    logic [31:0] icap_i, word_count;
    logic        csib2, rdwrb2, busy2, done2, err2;
    logic [31:0] icap2_i, count2;

    axis_icap_writer_if #(.DATA_WIDTH(DW))  s_axis ();
    axis_icap_writer_if #(.DATA_WIDTH(DW2)) s_axis2 ();

    axis_icap_writer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .BIT_SWAP(1), .LEN_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s_axis(s_axis),
        .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_avail(icap_avail),
        .busy(busy), .frame_done(frame_done), .word_count(word_count),
        .err_keep(err_keep), .err_clr(err_clr)
    );

    axis_icap_writer #(.DATA_WIDTH(DW2), .KEEP_WIDTH(DW2/8), .BIT_SWAP(0), .LEN_WIDTH(32)) dut2 (
        .clk(clk), .rst(rst), .s_axis(s_axis2),
        .icap_csib(csib2), .icap_rdwrb(rdwrb2), .icap_i(icap2_i), .icap_avail(1'b1),
        .busy(busy2), .frame_done(done2), .word_count(count2),
        .err_keep(err2), .err_clr(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          rand_avail = 0;
    obs_t        obs_q[$];
    int          done_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (icap_csib === 1'b0) obs_q.push_back('{w: icap_i, c: cyc});
        if (frame_done === 1'b1) done_q.push_back(cyc);
        if (rand_avail) icap_avail = ($urandom_range(0, 9) < 7);
    endtask

    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            int v, rv;
            v  = int'((w >> (8*b)) & 32'hFF);
            rv = 0;
            for (int i = 0; i < 8; i++)
                if (((v >> i) & 1) != 0) rv += 1 << (7 - i);
            r = r | (32'(rv) << (8*b));
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [KW-1:0] keep_prefix(input int n);
        logic [KW-1:0] k;
        for (int i = 0; i < KW; i++) k[i] = (i < 4*n);
        return k;
    endfunction

    // Words a beat should yield: the all-F lanes counted up from lane 0
    task automatic model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                              output int n, output bit kbad);
        n = 0;
        while (n < LANES && k[4*n +: 4] == 4'hF) n++;
        kbad = 1'b0;
        for (int i = 0; i < KW; i++)
            if (k[i] != (i < 4*n)) kbad = 1'b1;
        for (int j = 0; j < n; j++) exp_q.push_back(ref_swap(d[32*j +: 32]));
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, output int acc);
        bit was;
        int n;
        n   = 0;
        acc = -1;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        while (acc < 0 && n < 300) begin
            was = (s_axis.tready === 1'b1);
            tick();
            n++;
            if (was) acc = cyc;
        end
        s_axis.tvalid = 1'b0;
        chk("beat_accepted", acc >= 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        chk("idle_reached", busy, 0);
        tick();
        tick();
    endtask

    task automatic check_words(input string tag, input int base);
        chk({tag, "_nwords"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), obs_q[i].w, exp_q[i]);
            if (base >= 0) chk($sformatf("%s_cyc%0d", tag, i), obs_q[i].c, base + i);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [31:0]   hi;
        logic          tl;
        int            acc, acc1, acc2, n, nw, pn, wc_m, frames;
        bit            kb, err_exp, newf;

        rst = 1'b0;
        icap_avail = 1'b1;
        err_clr = 1'b0;
        s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
        s_axis2.tvalid = 1'b0; s_axis2.tdata = '0; s_axis2.tkeep = '0; s_axis2.tlast = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_tready", s_axis.tready, 0);
        chk("rst_csib", icap_csib, 1);
        chk("rst_rdwrb", icap_rdwrb, 0);
        chk("rst_icap_i", icap_i, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err_keep", err_keep, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_tready", s_axis.tready, 1);

        // Single full beat, tlast
        d = rnd_data();
        d[31:0] = 32'hAA995566;
        model_beat(d, '1, nw, kb);
        send_beat(d, '1, 1'b1, acc);
        chk("t1_first_word", icap_i, 32'h5599AA66);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 20; i++) tick();
        check_words("t1", acc);
        chk("t1_word_count", word_count, 16);
        chk("t1_done_n", done_q.size(), 1);
        if (done_q.size() > 0) chk("t1_done_cyc", done_q[0], acc + 16);
        chk("t1_err", err_keep, 0);
        done_q.delete();

        // Two back-to-back beats
        d = rnd_data();
        model_beat(d, '1, nw, kb);
        send_beat(d, '1, 1'b0, acc1);
        chk("t2_wc_restart", word_count, 1);
        d = rnd_data();
        model_beat(d, '1, nw, kb);
        send_beat(d, '1, 1'b1, acc2);
        chk("t2_no_bubble", acc2, acc1 + 16);
        for (int i = 0; i < 24; i++) tick();
        check_words("t2", acc1);
        chk("t2_word_count", word_count, 32);
        chk("t2_done_n", done_q.size(), 1);
        if (done_q.size() > 0) chk("t2_done_cyc", done_q[0], acc1 + 32);
        done_q.delete();

        // Partial keep, then a malformed keep
        d = rnd_data();
        k = 64'h0000_0000_0000_0FFF;
        model_beat(d, k, nw, kb);
        chk("t3_model_n", nw, 3);
        send_beat(d, k, 1'b1, acc);
        for (int i = 0; i < 6; i++) tick();
        check_words("t3a", acc);
        chk("t3a_err", err_keep, 0);
        chk("t3a_word_count", word_count, 3);
        done_q.delete();
        d = rnd_data();
        k = 64'h0000_0000_0000_00F3;
        model_beat(d, k, nw, kb);
        send_beat(d, k, 1'b1, acc);
        chk("t3b_err_set", err_keep, kb);
        chk("t3b_done_now", frame_done, 1);
        for (int i = 0; i < 4; i++) tick();
        check_words("t3b", -1);
        chk("t3b_done_n", done_q.size(), 1);
        chk("t3b_wc_hold", word_count, 3);
        chk("t3b_err_sticky", err_keep, 1);
        done_q.delete();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3c_err_clr", err_keep, 0);

        // AVAIL stall after the third word
        d = rnd_data();
        model_beat(d, '1, nw, kb);
        send_beat(d, '1, 1'b1, acc);
        tick(); tick();
        icap_avail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t4_stall_csib%0d", i), icap_csib, 1);
            chk($sformatf("t4_stall_word%0d", i), icap_i, exp_q[3]);
        end
        icap_avail = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_words("t4", -1);
        chk("t4_word_count", word_count, 16);
        chk("t4_done_n", done_q.size(), 1);
        done_q.delete();

        // Pass-through bit order on the narrow instance
        hi = $urandom;
        s_axis2.tdata = {hi, 32'h12345678};
        s_axis2.tkeep = '1;
        s_axis2.tlast = 1'b1;
        s_axis2.tvalid = 1'b1;
        n = 0;
        while (s_axis2.tready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("t5_ready", s_axis2.tready, 1);
        tick();
        s_axis2.tvalid = 1'b0;
        chk("t5_w0", icap2_i, 32'h12345678);
        chk("t5_csib", csib2, 0);
        tick();
        chk("t5_w1", icap2_i, hi);
        tick();
        chk("t5_done", done2, 1);
        chk("t5_count", count2, 2);
        chk("t5_err", err2, 0);
        chk("t5_idle", busy2, 0);
        chk("t5_rdwrb", rdwrb2, 0);
        done_q.delete();

        // Reset during the seventh word
        d = rnd_data();
        model_beat(d, '1, nw, kb);
        send_beat(d, '1, 1'b1, acc);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_words_before", obs_q.size(), 7);
        #1 rst = 1'b1;
        #1;
        chk("t6_csib", icap_csib, 1);
        chk("t6_tready", s_axis.tready, 0);
        chk("t6_word_count", word_count, 0);
        chk("t6_busy", busy, 0);
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("t6_no_done", done_q.size(), 0);
        d = rnd_data();
        model_beat(d, '1, nw, kb);
        send_beat(d, '1, 1'b1, acc);
        chk("t6_restart_wc", word_count, 1);
        for (int i = 0; i < 20; i++) tick();
        check_words("t6", acc);
        chk("t6_word_count_end", word_count, 16);
        chk("t6_done_n", done_q.size(), 1);
        done_q.delete();

        // Randomized beats, keeps and AVAIL
        wc_m = 16;
        newf = 1'b1;
        err_exp = 1'b0;
        frames = 0;
        rand_avail = 1;
        for (int b = 0; b < 10; b++) begin
            d = rnd_data();
            case ($urandom_range(0, 2))
                0: k = keep_prefix($urandom_range(0, LANES));
                1: k = {$urandom, $urandom};
                default: begin
                    pn = $urandom_range(0, LANES - 1);
                    k = keep_prefix(pn);
                    k[4*pn +: 4] = 4'($urandom_range(1, 14));
                end
            endcase
            tl = 1'($urandom_range(0, 1));
            model_beat(d, k, nw, kb);
            err_exp |= kb;
            if (nw > 0) begin
                wc_m = newf ? nw : wc_m + nw;
                newf = 1'b0;
            end
            if (tl) begin
                newf = 1'b1;
                frames++;
            end
            if (nw == 0 && tl) wait_idle();
            send_beat(d, k, tl, acc);
        end
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 800) begin tick(); n++; end
        rand_avail = 0;
        icap_avail = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_words("rnd", -1);
        chk("rnd_err", err_keep, err_exp);
        chk("rnd_frames", done_q.size(), frames);
        chk("rnd_word_count", word_count, wc_m);
        chk("rnd_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
